// File: rtl/ibex_alu_funnel_mc_pkg.sv
// Package for the multi-cycle rotate / funnel-shift unit.
// Provides the operation encoding shared by the unit, its bus interface and
// the bench, plus small decode helpers for the operation classes.
package ibex_alu_funnel_mc_pkg;

  typedef enum logic [1:0] {
    MC_ROL = 2'd0,
    MC_ROR = 2'd1,
    MC_FSL = 2'd2,
    MC_FSR = 2'd3
  } mc_shift_op_e;

  // Left-shifting operations: A is shifted left, B is shifted right.
  function automatic logic op_is_left(input mc_shift_op_e op);
    return (op == MC_ROL) || (op == MC_FSL);
  endfunction

  // Rotates use the first operand for both halves of the funnel.
  function automatic logic op_is_rot(input mc_shift_op_e op);
    return (op == MC_ROL) || (op == MC_ROR);
  endfunction

endpackage

// File: rtl/ibex_alu_funnel_mc_if.sv
// Request/response bus of the multi-cycle rotate / funnel-shift unit.
//   valid_i/ready_o : request handshake, op_i/rs1_i/rs2_i/rs3_i payload
//   kill_i          : abort any in-flight operation
//   valid_o/ready_i : result handshake, result_o payload
//   busy_o          : unit is not idle
// master = requester/consumer side, slave = the shift unit.
interface ibex_alu_funnel_mc_if #(
  parameter int Width = 32
);
  import ibex_alu_funnel_mc_pkg::*;

  logic               valid_i;
  logic               ready_o;
  mc_shift_op_e       op_i;
  logic [Width-1:0]   rs1_i;
  logic [Width-1:0]   rs2_i;
  logic [Width-1:0]   rs3_i;
  logic               kill_i;
  logic               valid_o;
  logic               ready_i;
  logic [Width-1:0]   result_o;
  logic               busy_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, rs3_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, rs3_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

endinterface

// File: rtl/ibex_alu_funnel_mc_shift_right.sv
// ibex_shift_right: combinational logical right shifter.
//   data_i  : Width-bit operand
//   shamt_i : log2(Width)-bit shift amount
//   data_o  : data_i >> shamt_i, zero filled
module ibex_shift_right
  import ibex_alu_funnel_mc_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [Width-1:0]         data_i,
  input  logic [$clog2(Width)-1:0] shamt_i,
  output logic [Width-1:0]         data_o
);

  assign data_o = data_i >> shamt_i;

endmodule

// File: rtl/ibex_alu_funnel_mc.sv
// ibex_alu_funnel_mc: multi-cycle ROL/ROR/FSL/FSR unit.
// A single right shifter is used twice per operation: FIRST forms the A term
// (shift by s), SECOND ORs in the B term (shift by W-s). Left shifts are done
// by bit-reversing around the right shifter. A zero effective shift skips
// the shifter and completes in one cycle.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : request/response bus (slave side), see ibex_alu_funnel_mc_if
module ibex_alu_funnel_mc
  import ibex_alu_funnel_mc_pkg::*;
#(
  parameter int Width = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  ibex_alu_funnel_mc_if.slave bus
);

  localparam int SW = $clog2(Width);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_e;

  always_comb begin : width_check
    assert ((Width >= 8) && (Width <= 64) && ((Width & (Width - 1)) == 0))
      else $error("ibex_alu_funnel_mc: Width must be a power of two in 8..64");
  end

  function automatic logic [Width-1:0] bit_rev(input logic [Width-1:0] x);
    logic [Width-1:0] r;
    for (int i = 0; i < Width; i++) r[i] = x[Width-1-i];
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [Width-1:0] imd_q, imd_d;
  logic [Width-1:0] result_q, result_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [SW-1:0]    s_q, s_d;
  logic             left_q, left_d;

  // Only rs2_i[SW:0] carries the amount; the upper bits are don't-care.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^bus.rs2_i[Width-1:SW+1];

  // Request decode: funnel amounts >= W swap the operands and wrap to t-W,
  // which is simply the low SW bits of t.
  logic [SW:0]      t_amt;
  logic [Width-1:0] cap_a, cap_b;
  logic [SW-1:0]    cap_s;
  logic             cap_left;

  always_comb begin
    t_amt    = bus.rs2_i[SW:0];
    cap_left = op_is_left(bus.op_i);
    cap_s    = t_amt[SW-1:0];
    cap_a    = bus.rs1_i;
    cap_b    = bus.rs3_i;
    if (op_is_rot(bus.op_i)) begin
      cap_b = bus.rs1_i;
    end else if (t_amt[SW]) begin
      cap_a = bus.rs3_i;
      cap_b = bus.rs1_i;
    end
  end

  // Shared shifter: A term by s in FIRST, B term by W-s (mod W) in SECOND.
  // Reversal is applied to whichever term shifts left.
  logic             sh_rev;
  logic [Width-1:0] sh_src, sh_in, sh_out, sh_term;
  logic [SW-1:0]    sh_amt;

  always_comb begin
    if (state_q == SECOND) begin
      sh_src = b_q;
      sh_amt = -s_q;
      sh_rev = ~left_q;
    end else begin
      sh_src = a_q;
      sh_amt = s_q;
      sh_rev = left_q;
    end
  end

  assign sh_in   = sh_rev ? bit_rev(sh_src) : sh_src;
  assign sh_term = sh_rev ? bit_rev(sh_out) : sh_out;

  ibex_shift_right #(.Width(Width)) u_shift_right (
    .data_i  (sh_in),
    .shamt_i (sh_amt),
    .data_o  (sh_out)
  );

  // Handshake: ready_o depends combinationally on ready_i in DONE; kill blocks acceptance.
  logic accept;
  assign bus.ready_o = ~bus.kill_i &
                       ((state_q == IDLE) | ((state_q == DONE) & bus.ready_i));
  assign accept      = bus.valid_i & bus.ready_o;

  always_comb begin
    state_d  = state_q;
    imd_d    = imd_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    left_d   = left_q;
    if (bus.kill_i) begin
      state_d = IDLE;
    end else if (accept) begin
      a_d    = cap_a;
      b_d    = cap_b;
      s_d    = cap_s;
      left_d = cap_left;
      if (cap_s == '0) begin
        state_d  = DONE;
        result_d = cap_a;
      end else begin
        state_d = FIRST;
      end
    end else begin
      unique case (state_q)
        FIRST: begin
          imd_d   = sh_term;
          state_d = SECOND;
        end
        SECOND: begin
          result_d = imd_q | sh_term;
          state_d  = DONE;
        end
        DONE: begin
          if (bus.ready_i) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      imd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      imd_q    <= imd_d;
      result_q <= result_d;
    end
  end

  // Captured operands, only meaningful after an accept
  always_ff @(posedge clk_i) begin
    a_q    <= a_d;
    b_q    <= b_d;
    s_q    <= s_d;
    left_q <= left_d;
  end

  assign bus.valid_o  = (state_q == DONE);
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_ibex_alu_funnel_mc.sv
module tb_ibex_alu_funnel_mc;
  import ibex_alu_funnel_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ibex_alu_funnel_mc_if #(.Width(32)) bus32 ();
  ibex_alu_funnel_mc_if #(.Width(64)) bus64 ();

  ibex_alu_funnel_mc #(.Width(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  ibex_alu_funnel_mc #(.Width(64)) dut64 (.clk_i(clk), .rst_i(rst), .bus(bus64));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input bit w);
    return w ? bus64.ready_o : bus32.ready_o;
  endfunction
  function automatic logic get_vld(input bit w);
    return w ? bus64.valid_o : bus32.valid_o;
  endfunction
  function automatic logic get_busy(input bit w);
    return w ? bus64.busy_o : bus32.busy_o;
  endfunction
  function automatic logic [63:0] get_res(input bit w);
    return w ? bus64.result_o : {32'h0, bus32.result_o};
  endfunction

  task automatic drive(input bit w, input logic v, input mc_shift_op_e op,
                       input logic [63:0] a, input logic [63:0] amt, input logic [63:0] b);
    if (w) begin
      bus64.valid_i = v; bus64.op_i = op;
      bus64.rs1_i = a; bus64.rs2_i = amt; bus64.rs3_i = b;
    end else begin
      bus32.valid_i = v; bus32.op_i = op;
      bus32.rs1_i = a[31:0]; bus32.rs2_i = amt[31:0]; bus32.rs3_i = b[31:0];
    end
  endtask

  task automatic clr_valid(input bit w);
    if (w) bus64.valid_i = 1'b0;
    else   bus32.valid_i = 1'b0;
  endtask

  // Waits (bounded) for valid_o; lat counts cycles since the accept edge.
  task automatic wait_result(input bit w, output int lat);
    lat = 1;
    while (!get_vld(w) && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input bit w, input mc_shift_op_e op,
                       input logic [63:0] a, input logic [63:0] amt, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    drive(w, 1'b1, op, a, amt, b);
    check({tag, "_rdy"}, 64'(get_rdy(w)), 64'd1);
    @(negedge clk);
    clr_valid(w);
    wait_result(w, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, get_res(w), exp);
  endtask

  initial begin
    int lat;
    bit seen;
    bus32.valid_i = 0; bus32.op_i = MC_ROL; bus32.rs1_i = 0; bus32.rs2_i = 0;
    bus32.rs3_i = 0; bus32.kill_i = 0; bus32.ready_i = 1;
    bus64.valid_i = 0; bus64.op_i = MC_ROL; bus64.rs1_i = 0; bus64.rs2_i = 0;
    bus64.rs3_i = 0; bus64.kill_i = 0; bus64.ready_i = 1;

    #2 rst = 1'b1;
    #1;
    check("rst_rdy",   64'(bus32.ready_o), 64'd1);
    check("rst_vld",   64'(bus32.valid_o), 64'd0);
    check("rst_busy",  64'(bus32.busy_o),  64'd0);
    check("rst_res",   64'(bus32.result_o), 64'd0);
    check("rst_vld64", 64'(bus64.valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // W=32 directed vectors
    do_op("ror4",    0, MC_ROR, 64'h8000_0001, 64'd4,  64'h0,         64'h1800_0000, 3);
    do_op("rol8",    0, MC_ROL, 64'h1234_5678, 64'd8,  64'h0,         64'h3456_7812, 3);
    do_op("rol40",   0, MC_ROL, 64'h1234_5678, 64'd40, 64'h0,         64'h3456_7812, 3);
    do_op("ror32",   0, MC_ROR, 64'h1234_5678, 64'd32, 64'h0,         64'h1234_5678, 1);
    do_op("fsl8",    0, MC_FSL, 64'h1234_5678, 64'd8,  64'h9ABC_DEF0, 64'h3456_789A, 3);
    do_op("fsl40",   0, MC_FSL, 64'h1234_5678, 64'd40, 64'h9ABC_DEF0, 64'hBCDE_F012, 3);
    do_op("fsl32",   0, MC_FSL, 64'h1234_5678, 64'd32, 64'h9ABC_DEF0, 64'h9ABC_DEF0, 1);
    do_op("fsl0",    0, MC_FSL, 64'h1234_5678, 64'd0,  64'h9ABC_DEF0, 64'h1234_5678, 1);
    do_op("fsr4",    0, MC_FSR, 64'h1234_5678, 64'd4,  64'h9ABC_DEF1, 64'h1123_4567, 3);

    // W=64 directed vectors
    do_op("w64_ror1",  1, MC_ROR, 64'h1, 64'd1, 64'h0, 64'h8000_0000_0000_0000, 3);
    do_op("w64_fsl64", 1, MC_FSL, 64'h1111_2222_3333_4444, 64'd64,
          64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1);

    // Backpressure: hold result in DONE, then release with a same-cycle accept
    @(negedge clk);
    bus32.ready_i = 1'b0;
    drive(0, 1'b1, MC_FSR, 64'h1234_5678, 64'd4, 64'h9ABC_DEF1);
    @(negedge clk);
    clr_valid(0);
    wait_result(0, lat);
    check("bp_lat", 64'(lat), 64'd3);
    check("bp_res", get_res(0), 64'h1123_4567);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_res", get_res(0), 64'h1123_4567);
      check("bp_hold_rdy", 64'(get_rdy(0)), 64'd0);
      check("bp_hold_vld", 64'(get_vld(0)), 64'd1);
    end
    bus32.ready_i = 1'b1;
    drive(0, 1'b1, MC_ROL, 64'h1234_5678, 64'd8, 64'h0);
    #1 check("bp_rel_rdy", 64'(get_rdy(0)), 64'd1);
    @(negedge clk);
    clr_valid(0);
    check("bp_rel_busy", 64'(get_busy(0)), 64'd1);
    check("bp_rel_vld",  64'(get_vld(0)),  64'd0);
    wait_result(0, lat);
    check("bp_rel_lat", 64'(lat), 64'd3);
    check("bp_rel_res", get_res(0), 64'h3456_7812);

    // Kill in SECOND
    @(negedge clk);
    drive(0, 1'b1, MC_ROL, 64'hCAFE_0001, 64'd8, 64'h0);
    @(negedge clk);
    clr_valid(0);
    @(negedge clk);
    check("kill_busy_second", 64'(get_busy(0)), 64'd1);
    bus32.kill_i = 1'b1;
    #1 check("kill_rdy", 64'(get_rdy(0)), 64'd0);
    @(negedge clk);
    bus32.kill_i = 1'b0;
    check("kill_idle", 64'(get_busy(0)), 64'd0);
    check("kill_vld",  64'(get_vld(0)),  64'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (get_vld(0)) seen = 1'b1;
    end
    check("kill_no_vld", 64'(seen), 64'd0);
    check("kill_res_kept", get_res(0), 64'h3456_7812);

    // Kill in IDLE blocks acceptance
    @(negedge clk);
    bus32.kill_i = 1'b1;
    drive(0, 1'b1, MC_ROR, 64'h8000_0001, 64'd4, 64'h0);
    #1 check("kill_idle_rdy", 64'(get_rdy(0)), 64'd0);
    @(negedge clk);
    bus32.kill_i = 1'b0;
    clr_valid(0);
    check("kill_idle_noacc", 64'(get_busy(0)), 64'd0);

    // Asynchronous reset while in FIRST
    @(negedge clk);
    drive(0, 1'b1, MC_ROR, 64'h8000_0001, 64'd4, 64'h0);
    @(negedge clk);
    clr_valid(0);
    check("rstmid_busy_pre", 64'(get_busy(0)), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_vld",  64'(get_vld(0)),  64'd0);
    check("rstmid_busy", 64'(get_busy(0)), 64'd0);
    check("rstmid_rdy",  64'(get_rdy(0)),  64'd1);
    check("rstmid_res",  get_res(0),       64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("post_rst_ror16", 0, MC_ROR, 64'h1234_5678, 64'd16, 64'h0, 64'h5678_1234, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ibex_alu_funnel_mc.md
# ibex_alu_funnel_mc

Parametrised multi-cycle rotate and funnel-shift unit for bitmanip ROL/ROR/FSL/FSR at configurable datapath width. One shared right-shifter runs twice per operation, with intermediate state held internally. Sits beside the ALU in the EX stage behind a valid/ready handshake, with backpressure and a kill input. Zero effective shift completes in one cycle.

## Interface
- Width, 32: datapath width W; power of two, 8..64.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  mc_shift_op_e  MC_ROL / MC_ROR / MC_FSL / MC_FSR.
- rs1_i  in  W  operand A.
- rs2_i  in  W  shift amount; bits [log2(W):0] used.
- rs3_i  in  W  funnel operand B; ignored for rotates.
- kill_i  in  1  abort any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  W  result; held stable while valid_o && !ready_i.
- busy_o  out  1  state != IDLE.

## Operation
- Capture on valid_i && ready_o: op, A = rs1, B = rs3 (rotates: B = rs1), amount.
- Rotate amount: s = rs2[log2(W)-1:0].
- Funnel amount: t = rs2[log2(W):0]. If t >= W, swap A/B and set s = t - W; otherwise s = t.
- ROL, FSL: result = (A << s) | (B >> (W-s)).
- ROR, FSR: result = (A >> s) | (B << (W-s)).
- If s == 0: result = A after any swap (FSL/FSR with t = W returns rs3).
- Left shifts use bit-reverse, right-shift, then bit-reverse, so only one right-shifter exists.
- Shift amounts W-s are computed modulo W in log2(W) bits. The s == 0 case never reaches the shifter.
- FSM states: IDLE, FIRST, SECOND, DONE.
  - IDLE: accept. If s == 0, go to DONE with result_q = A; else go to FIRST.
  - FIRST: imd_q = A-term (shift by s). Go to SECOND.
  - SECOND: result_q = imd_q | B-term (shift by W-s). Go to DONE.
  - DONE: valid_o = 1. On ready_i, go to IDLE, or accept a new request in the same cycle.
- ready_o = (state == IDLE) || (state == DONE && ready_i). This is a combinational ready_i-to-ready_o path.
- kill_i has priority over all transitions: go to IDLE next cycle, discard the operation, and accept nothing that cycle (ready_o = 0 while kill_i).
- Signed values are never involved; all shifts are logical.

## Timing
- Reset values: state IDLE, valid_o 0, result_o 0, busy_o 0, ready_o 1, imd_q 0.
- Accept at edge T.
  - Nonzero shift: FIRST in T+1, SECOND in T+2, valid_o high in T+3.
  - Zero shift: valid_o high in T+1.
- Throughput: one operation per 3 cycles with ready_i held high (back-to-back accept in DONE).
- Backpressure: DONE holds result_o and valid_o indefinitely; ready_o stays 0 while ready_i = 0.
- kill_i in DONE together with ready_i: counts as kill. No new accept; the result is treated as consumed.
- Reset mid-operation: all state clears immediately (asynchronous); valid_o drops without an edge.
- Operands and op are sampled only at accept; changes during FIRST/SECOND have no effect.

## Structure
- ibex_pkg adds typedef enum logic [1:0] mc_shift_op_e {MC_ROL, MC_ROR, MC_FSL, MC_FSR}.
- FSM state enum stays local to the module.
- Sub-module ibex_shift_right #(Width): combinational logical right-shifter of W bits by log2(W) bits, instantiated once. Bit-reversal wrapping stays in the parent.
- A combinational assertion checks that Width is a power of two in 8..64.

## Test plan
- ROR, W=32, rs1=0x8000_0001, rs2=4, ready_i=1 -> result 0x1800_0000; valid_o exactly 3 cycles after accept.
- ROL rs1=0x1234_5678, rs2=8 -> 0x3456_7812. Same with rs2=40 (amount masked to 8) -> 0x3456_7812.
- FSL rs1=0x1234_5678, rs3=0x9ABC_DEF0:
  - rs2=8 -> 0x3456_789A.
  - rs2=40 -> 0xBCDE_F012.
  - rs2=32 -> 0x9ABC_DEF0 with valid_o 1 cycle after accept.
  - rs2=0 -> 0x1234_5678.
- FSR rs1=0x1234_5678, rs3=0x9ABC_DEF1, rs2=4 -> 0x1123_4567.
- Backpressure and kill:
  - Hold ready_i=0 for 5 cycles in DONE -> result_o stable, ready_o 0; release -> new request accepted the same cycle.
  - kill_i in SECOND -> IDLE next cycle, valid_o never asserts.
  - rst_i pulse in FIRST -> all outputs at reset values immediately.
- W=64: ROR rs1=0x1, rs2=1 -> 0x8000_0000_0000_0000. FSL with rs2=64 -> rs3 returned.
